// File: rtl/mem_stage.sv
// Memory-access pipeline stage: sized load/store, multi-cycle access FSM, branch resolution, MEM/WB registers.
// Optional access statistics outputs are enabled by defining MEM_STATS_EN.
module mem_stage #(
    parameter int MEM_DEPTH   = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic [4:0]  reg_dst,
    input  logic        zero,
    input  logic [31:0] branch_addr,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    output logic        mem_busy,
    output logic        pc_src,
    output logic [31:0] pc_branch_target,
    output logic        misaligned,
    output logic        wb_valid,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_reg_dst,
    output logic        wb_RegWrite,
    output logic        wb_MemtoReg
`ifdef MEM_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_stall_cycles
`endif
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] alu_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic        read_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        regwrite_q;
    logic        memtoreg_q;

    logic [31:0] mem [MEM_DEPTH];

    logic          accept;
    logic          memOpIn;
    logic          complete_d;
    logic          startWait_d;
    logic [31:0]   srcAlu;
    logic [31:0]   srcWdata;
    logic [4:0]    srcRd;
    logic          srcRead;
    logic          srcWrite;
    logic [1:0]    srcSize;
    logic          srcSigned;
    logic          srcRegWrite;
    logic          srcMemtoReg;
    logic          isLoad;
    logic          isStore;
    logic          misalign_d;
    logic [AW-1:0] wordIdx;
    logic [31:0]   memWord;
    logic [7:0]    loadByte;
    logic [15:0]   loadHalf;
    logic [31:0]   loadData_d;
    logic [31:0]   storeWord_d;
    logic          memWe;
    logic          unused_addr;

    assign mem_busy    = (state_q == S_WAIT);
    assign accept      = in_valid & ~mem_busy;
    assign memOpIn     = MemRead | MemWrite;
    assign unused_addr = ^srcAlu[31:AW+2];

    // While waiting, the access is driven from the latched copy; upstream values are ignored.
    always_comb begin
        srcAlu      = mem_busy ? alu_q      : alu_result;
        srcWdata    = mem_busy ? wdata_q    : write_data;
        srcRd       = mem_busy ? rd_q       : reg_dst;
        srcRead     = mem_busy ? read_q     : MemRead;
        srcWrite    = mem_busy ? write_q    : MemWrite;
        srcSize     = mem_busy ? size_q     : MemSize;
        srcSigned   = mem_busy ? signed_q   : MemSigned;
        srcRegWrite = mem_busy ? regwrite_q : RegWrite;
        srcMemtoReg = mem_busy ? memtoreg_q : MemtoReg;

        complete_d  = mem_busy ? (cnt_q == 4'd1)
                               : (accept && (!memOpIn || MEM_LATENCY == 1));
        startWait_d = !mem_busy && accept && memOpIn && (MEM_LATENCY > 1);

        isStore = srcWrite;
        isLoad  = srcRead & ~srcWrite;

        case (srcSize)
            2'b00:   misalign_d = 1'b0;
            2'b01:   misalign_d = srcAlu[0];
            default: misalign_d = (srcAlu[1:0] != 2'b00);
        endcase
        misalign_d = misalign_d & (srcRead | srcWrite);

        wordIdx  = srcAlu[AW+1:2];
        memWord  = mem[wordIdx];
        loadByte = memWord[{srcAlu[1:0], 3'b000} +: 8];
        loadHalf = srcAlu[1] ? memWord[31:16] : memWord[15:0];

        case (srcSize)
            2'b00:   loadData_d = {{24{srcSigned & loadByte[7]}}, loadByte};
            2'b01:   loadData_d = {{16{srcSigned & loadHalf[15]}}, loadHalf};
            default: loadData_d = memWord;
        endcase

        storeWord_d = memWord;
        case (srcSize)
            2'b00: storeWord_d[{srcAlu[1:0], 3'b000} +: 8] = srcWdata[7:0];
            2'b01: begin
                if (srcAlu[1]) storeWord_d[31:16] = srcWdata[15:0];
                else           storeWord_d[15:0]  = srcWdata[15:0];
            end
            default: storeWord_d = srcWdata;
        endcase

        memWe = complete_d & isStore & ~misalign_d;
    end

    // Gating with reset keeps an access from landing while the stage is held in reset.
    always_ff @(posedge clk) begin
        if (memWe && reset) begin
            mem[wordIdx] <= storeWord_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            cnt_q            <= 4'd0;
            alu_q            <= 32'd0;
            wdata_q          <= 32'd0;
            rd_q             <= 5'd0;
            read_q           <= 1'b0;
            write_q          <= 1'b0;
            size_q           <= 2'b00;
            signed_q         <= 1'b0;
            regwrite_q       <= 1'b0;
            memtoreg_q       <= 1'b0;
            pc_src           <= 1'b0;
            pc_branch_target <= 32'd0;
            misaligned       <= 1'b0;
            wb_valid         <= 1'b0;
            wb_read_data     <= 32'd0;
            wb_alu_result    <= 32'd0;
            wb_reg_dst       <= 5'd0;
            wb_RegWrite      <= 1'b0;
            wb_MemtoReg      <= 1'b0;
        end else begin
            pc_src <= accept & Branch & zero;
            if (accept && Branch && zero) begin
                pc_branch_target <= branch_addr;
            end

            case (state_q)
                S_IDLE: begin
                    if (startWait_d) begin
                        state_q    <= S_WAIT;
                        cnt_q      <= 4'(MEM_LATENCY - 1);
                        alu_q      <= alu_result;
                        wdata_q    <= write_data;
                        rd_q       <= reg_dst;
                        read_q     <= MemRead;
                        write_q    <= MemWrite;
                        size_q     <= MemSize;
                        signed_q   <= MemSigned;
                        regwrite_q <= RegWrite;
                        memtoreg_q <= MemtoReg;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= S_IDLE;
                    end
                    cnt_q <= cnt_q - 4'd1;
                end
                default: state_q <= S_IDLE;
            endcase

            wb_valid    <= complete_d;
            misaligned  <= complete_d & misalign_d;
            wb_RegWrite <= complete_d & srcRegWrite & ~isStore & ~misalign_d;
            if (complete_d) begin
                wb_read_data  <= (isLoad && !misalign_d) ? loadData_d : 32'd0;
                wb_alu_result <= srcAlu;
                wb_reg_dst    <= srcRd;
                wb_MemtoReg   <= srcMemtoReg;
            end
        end
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_loads        <= 32'd0;
            stat_stores       <= 32'd0;
            stat_stall_cycles <= 32'd0;
        end else begin
            if (complete_d && isLoad && !misalign_d) begin
                stat_loads <= stat_loads + 32'd1;
            end
            if (complete_d && isStore && !misalign_d) begin
                stat_stores <= stat_stores + 32'd1;
            end
            if (mem_busy) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage. Consumes the ALU result, store data, destination register, zero flag and branch target produced by execute.
- Performs data-memory load/store with byte/half/word sizing and a configurable multi-cycle access latency. Back-pressures upstream while an access is in flight.
- Resolves branches and drives the registered MEM/WB pipeline outputs consumed by write-back.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words in the internal data memory; power of two.
- MEM_LATENCY, 2, cycles from accept to wb_valid for load/store ops; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  execute-stage result valid this cycle
- alu_result  in  32  effective address or ALU value
- write_data  in  32  store data (rt value)
- reg_dst  in  5  destination register
- zero  in  1  ALU zero flag
- branch_addr  in  32  branch target
- Branch  in  1  instruction is a conditional branch
- MemRead  in  1  load
- MemWrite  in  1  store
- MemSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- MemSigned  in  1  sign-extend sub-word loads
- RegWrite  in  1  write-back enable
- MemtoReg  in  1  write-back selects load data
- mem_busy  out  1  stall upstream; combinational, high in WAIT state
- pc_src  out  1  registered one-cycle pulse: take branch
- pc_branch_target  out  32  registered branch target, valid with pc_src
- misaligned  out  1  registered one-cycle pulse: misaligned access dropped
- wb_valid  out  1  MEM/WB entry valid
- wb_read_data  out  32  load data after size/sign handling
- wb_alu_result  out  32  passed-through alu_result
- wb_reg_dst  out  5  passed-through reg_dst
- wb_RegWrite  out  1  qualified write-back enable
- wb_MemtoReg  out  1  passed-through MemtoReg

Behaviour:
- Reset (reset=0, async): all outputs and state cleared to 0; FSM=IDLE. Memory array is not cleared.
- Accept condition: in_valid & ~mem_busy. All inputs are latched on accept; upstream must hold its values while mem_busy is high, but the block ignores them.
- FSM states: IDLE and WAIT.
  - Non-memory op (MemRead=MemWrite=0): stays in IDLE. MEM/WB outputs are registered at the next edge, so latency is 1.
  - Memory op with MEM_LATENCY=1: behaves like a non-memory op.
  - Memory op with MEM_LATENCY>1: IDLE->WAIT with counter=MEM_LATENCY-1. Counter decrements each cycle. At counter==1 the access completes, outputs are registered, and the FSM returns to IDLE. Total latency is MEM_LATENCY cycles from the accept edge to wb_valid=1.
- MemRead and MemWrite both set: treated as a store, with wb_RegWrite forced to 0.
- Memory write occurs only on the completion edge. Reset during WAIT aborts the access: no write, wb_valid stays 0.
- wb_valid is a one-cycle pulse per accepted op. When wb_valid=0, wb_RegWrite=0; the other wb_* fields hold their last values.
- Addressing: word index = alu_result[log2(MEM_DEPTH)+1:2]; upper bits are ignored, so addresses wrap modulo MEM_DEPTH*4. Little-endian byte lanes.
- Loads:
  - Byte: lane addr[1:0].
  - Half: lanes {addr[1],1} : {addr[1],0}.
  - Word: all four lanes.
  - Zero- or sign-extended per MemSigned.
  - Non-load ops: wb_read_data=0.
- Stores:
  - Byte: write_data[7:0] into lane addr[1:0].
  - Half: write_data[15:0] into lanes selected by addr[1].
  - Word: full word.
  - Other lanes are unchanged.
- Misalignment (half with addr[0]=1; word with addr[1:0]!=0):
  - No memory access.
  - wb_RegWrite=0, wb_read_data=0, wb_valid=1.
  - misaligned pulses with wb_valid.
  - Full latency still applies.
- Branch: pc_src=1 on the edge after accept iff Branch & zero; pc_branch_target=branch_addr. pc_src is 0 in all other cycles.
- Back-to-back non-memory ops: one per cycle, with no bubbles.

Optional Feature:
- Macro MEM_STATS_EN. When defined, adds three 32-bit outputs, each wrapping, each cleared by reset:
  - stat_loads: completed aligned loads.
  - stat_stores: completed aligned stores.
  - stat_stall_cycles: cycles with mem_busy=1.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Word store then load, MEM_LATENCY=2: store 0xDEADBEEF at addr 0x10 -> mem_busy high 1 cycle, wb_valid at cycle 2, wb_RegWrite=0. Load 0x10 -> wb_read_data=0xDEADBEEF, wb_valid 2 cycles after accept.
- Sub-word access on word 0x11223344 at 0x20:
  - lb 0x23 signed -> 0x00000011.
  - sb 0x80 to 0x21, then lb signed 0x21 -> 0xFFFFFF80; lbu -> 0x00000080.
  - lh signed 0x22 -> 0x00001122.
- Misaligned lw at 0x22 with RegWrite=1 -> misaligned=1, wb_valid=1, wb_RegWrite=0, wb_read_data=0, memory unchanged.
- Branch: Branch=1, zero=1, branch_addr=0x00400040 -> next cycle pc_src=1, pc_branch_target=0x00400040. With zero=0 -> pc_src=0.
- Back-to-back ALU ops (alu_result 5, 6, 7; reg_dst 8, 9, 10) -> wb_valid on 3 consecutive cycles with matching fields, mem_busy never high.
- Reset mid-WAIT (MEM_LATENCY=4, store 0xAAAAAAAA at 0x40, reset asserted cycle 2) -> outputs 0 immediately; subsequent load 0x40 returns the prior value.
